// File: rtl/sr_pulse_driver.sv
// Set/reset pulse driver for a cross-coupled NOR SR latch: one width-controlled
// pulse per accepted level request, a dead-time gap after it, and a model of the latch's Q.
//
//   state  | meaning
//   IDLE   | waiting for a request; req_ready high unless in reset
//   PULSE  | driving s (level 1) or r (level 0) for PULSE_W cycles
//   GAP    | s = r = 0 for GAP_W cycles before the next request
module sr_pulse_driver #(
   parameter int PULSE_W = 4,
   parameter int GAP_W   = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_level,
   output logic req_ready,
   output logic s,
   output logic r,
   output logic busy,
   output logic q_model,
   output logic q_known,
   output logic skip
);

   localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CW    = (MAX_W < 1) ? 1 : $clog2(MAX_W + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PULSE = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          s_q, s_d;
   logic          r_q, r_d;
   logic          q_model_q, q_model_d;
   logic          q_known_q, q_known_d;
   logic          skip_q, skip_d;
   logic          accept;
   logic          redundant;

   assign req_ready = (state_q == ST_IDLE) & ~rst;
   assign accept    = req_valid & req_ready;
   assign redundant = q_known_q & (req_level == q_model_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      lvl_d     = lvl_q;
      s_d       = s_q;
      r_d       = r_q;
      q_model_d = q_model_q;
      q_known_d = q_known_q;
      skip_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_d = 1'b0;
            r_d = 1'b0;
            if (accept) begin
               if (redundant) begin
                  skip_d = 1'b1;
               end else begin
                  state_d = ST_PULSE;
                  cnt_d   = PULSE_LD;
                  lvl_d   = req_level;
                  s_d     = req_level;
                  r_d     = ~req_level;
               end
            end
         end
         ST_PULSE: begin
            if (cnt_q == CNT_ONE) begin
               s_d       = 1'b0;
               r_d       = 1'b0;
               q_model_d = lvl_q;
               q_known_d = 1'b1;
               if (GAP_W == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GAP;
                  cnt_d   = GAP_LD;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         ST_GAP: begin
            s_d = 1'b0;
            r_d = 1'b0;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            s_d     = 1'b0;
            r_d     = 1'b0;
         end
      endcase
   end

   // Reset clears the Q model too: after reset the latch level is unknown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         lvl_q     <= 1'b0;
         s_q       <= 1'b0;
         r_q       <= 1'b0;
         q_model_q <= 1'b0;
         q_known_q <= 1'b0;
         skip_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         lvl_q     <= lvl_d;
         s_q       <= s_d;
         r_q       <= r_d;
         q_model_q <= q_model_d;
         q_known_q <= q_known_d;
         skip_q    <= skip_d;
      end
   end

   assign s       = s_q;
   assign r       = r_q;
   assign busy    = (state_q != ST_IDLE);
   assign q_model = q_model_q;
   assign q_known = q_known_q;
   assign skip    = skip_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: instance A uses PULSE_W=4/GAP_W=2, instance B uses PULSE_W=1/GAP_W=0.
module tb_sr_pulse_driver;

   logic clk;
   logic rst_a, vld_a, lvl_a;
   logic rdy_a, s_a, r_a, busy_a, qm_a, qk_a, skip_a;
   logic rst2, vld_b, lvl_b;
   logic rdy_b, s_b, r_b, busy_b, qm_b, qk_b, skip_b;

   integer n_tests = 0;
   integer n_fail  = 0;
   logic   done    = 1'b0;

   logic [6:0] got, exp;

   sr_pulse_driver #(.PULSE_W(4), .GAP_W(2)) dut_a (
      .clk(clk), .rst(rst_a), .req_valid(vld_a), .req_level(lvl_a),
      .req_ready(rdy_a), .s(s_a), .r(r_a), .busy(busy_a),
      .q_model(qm_a), .q_known(qk_a), .skip(skip_a)
   );

   sr_pulse_driver #(.PULSE_W(1), .GAP_W(0)) dut_b (
      .clk(clk), .rst(rst2), .req_valid(vld_b), .req_level(lvl_b),
      .req_ready(rdy_b), .s(s_b), .r(r_b), .busy(busy_b),
      .q_model(qm_b), .q_known(qk_b), .skip(skip_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // s and r must never be high together on either instance
   always @(negedge clk) begin
      if (!done) begin
         n_tests++;
         if (((s_a & r_a) | (s_b & r_b)) !== 1'b0) begin
            $display("FAIL s_and_r_overlap t=%0t a:s=%b r=%b b:s=%b r=%b want s&r=0", $time, s_a, r_a, s_b, r_b);
            n_fail++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Vector order: {s, r, busy, q_model, q_known, req_ready, skip}
   task automatic test_reset();
      rst_a = 1'b1; rst2 = 1'b1;
      vld_a = 1'b1; lvl_a = 1'b1;
      vld_b = 1'b1; lvl_b = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         exp = 7'b0000000;
         n_tests++;
         if (got !== exp) begin
            $display("FAIL reset_hold_a c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         got = {s_b, r_b, busy_b, qm_b, qk_b, rdy_b, skip_b};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL reset_hold_b c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
      end
      rst_a = 1'b0; rst2 = 1'b0;
      vld_a = 1'b0; vld_b = 1'b0;
      #1;
      got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
      exp = 7'b0000010;
      n_tests++;
      if (got !== exp) begin
         $display("FAIL reset_release_a got %b want %b", got, exp);
         n_fail++;
      end
      step();
      got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
      n_tests++;
      if (got !== exp) begin
         $display("FAIL reset_after_a got %b want %b", got, exp);
         n_fail++;
      end
      got = {s_b, r_b, busy_b, qm_b, qk_b, rdy_b, skip_b};
      n_tests++;
      if (got !== exp) begin
         $display("FAIL reset_after_b got %b want %b", got, exp);
         n_fail++;
      end
   endtask

   task automatic test_set();
      vld_a = 1'b1; lvl_a = 1'b1;
      step();
      vld_a = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         exp = {(c <= 4), 1'b0, (c <= 6), (c >= 5), (c >= 5), (c >= 7), 1'b0};
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL set c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         if (c < 7) step();
      end
   endtask

   task automatic test_set_then_reset();
      vld_a = 1'b1; lvl_a = 1'b0;
      step();
      vld_a = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         exp = {1'b0, (c <= 4), (c <= 6), (c < 5), 1'b1, (c >= 7), 1'b0};
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL set_then_reset c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         if (c < 7) step();
      end
   endtask

   task automatic test_redundant();
      vld_a = 1'b1; lvl_a = 1'b1;
      step();
      vld_a = 1'b0;
      repeat (6) step();
      for (int c = 0; c <= 4; c++) begin
         vld_a = (c < 3);
         lvl_a = 1'b1;
         exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, (c >= 1 && c <= 3)};
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL redundant c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         step();
      end
      vld_a = 1'b0;
   endtask

   task automatic test_held_busy();
      for (int c = 0; c <= 8; c++) begin
         vld_a = (c < 7);
         lvl_a = (c == 0) ? 1'b0 : c[0];
         if (c == 0)
            exp = 7'b0001110;
         else if (c <= 6)
            exp = {1'b0, (c <= 4), 1'b1, (c < 5), 1'b1, 1'b0, 1'b0};
         else
            exp = 7'b0000110;
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL held_busy c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         step();
      end
      vld_a = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      vld_a = 1'b1; lvl_a = 1'b1;
      step();
      vld_a = 1'b0;
      got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
      exp = 7'b1010100;
      n_tests++;
      if (got !== exp) begin
         $display("FAIL midrst_c1 got %b want %b", got, exp);
         n_fail++;
      end
      step();
      rst_a = 1'b1;
      #1;
      got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
      exp = 7'b1010100;
      n_tests++;
      if (got !== exp) begin
         $display("FAIL midrst_c2 got %b want %b", got, exp);
         n_fail++;
      end
      step();
      got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
      exp = 7'b0000000;
      n_tests++;
      if (got !== exp) begin
         $display("FAIL midrst_c3 got %b want %b", got, exp);
         n_fail++;
      end
      rst_a = 1'b0;
      vld_a = 1'b1; lvl_a = 1'b0;
      #1;
      n_tests++;
      if (rdy_a !== 1'b1) begin
         $display("FAIL midrst_ready got %b want 1", rdy_a);
         n_fail++;
      end
      step();
      vld_a = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         exp = {1'b0, (c <= 4), (c <= 6), 1'b0, (c >= 5), (c >= 7), 1'b0};
         got = {s_a, r_a, busy_a, qm_a, qk_a, rdy_a, skip_a};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL midrst_repulse c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         if (c < 7) step();
      end
   endtask

   task automatic test_gap0();
      int  p;
      logic lv, pv;
      vld_b = 1'b1;
      for (int c = 0; c <= 8; c++) begin
         lvl_b = (((c / 2) % 2) == 0);
         if (c == 0) begin
            exp = 7'b0000010;
         end else if (c % 2 == 1) begin
            p  = (c - 1) / 2;
            lv = ((p % 2) == 0);
            pv = (p > 0) ? (((p - 1) % 2) == 0) : 1'b0;
            exp = {lv, ~lv, 1'b1, pv, (p > 0), 1'b0, 1'b0};
         end else begin
            p  = (c - 2) / 2;
            lv = ((p % 2) == 0);
            exp = {1'b0, 1'b0, 1'b0, lv, 1'b1, 1'b1, 1'b0};
         end
         got = {s_b, r_b, busy_b, qm_b, qk_b, rdy_b, skip_b};
         n_tests++;
         if (got !== exp) begin
            $display("FAIL gap0 c=%0d got %b want %b", c, got, exp);
            n_fail++;
         end
         step();
      end
      vld_b = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; rst2 = 1'b1;
      vld_a = 1'b0; lvl_a = 1'b0;
      vld_b = 1'b0; lvl_b = 1'b0;
      #1;
      test_reset();
      test_set();
      test_set_then_reset();
      test_redundant();
      test_held_busy();
      test_reset_mid_pulse();
      test_gap0();
      repeat (2) step();
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
